// File: rtl/fair_pick.sv
// Fair picker: selects the valid channel with the oldest wrap-aware count,
// breaking ties in round-robin order, and holds the pick until it is accepted.
module fair_pick #(
    parameter int NUM_IN_LOG2 = 3,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CNT_W-1:0]       count   [2**NUM_IN_LOG2],
    input  logic                   valid_i [2**NUM_IN_LOG2],
    input  logic                   ready_i,
    output logic [NUM_IN_LOG2-1:0] pick,
    output logic [CNT_W-1:0]       pick_count,
    output logic                   valid_o
);

    localparam int N = 2**NUM_IN_LOG2;

    typedef enum logic {
        EMPTY,
        HOLD
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [NUM_IN_LOG2-1:0] r_pick;
    logic [CNT_W-1:0]       r_pickCount;
    logic [NUM_IN_LOG2-1:0] r_rrPtr;

    logic [NUM_IN_LOG2-1:0] w_base;
    logic [NUM_IN_LOG2-1:0] w_idx;
    logic [CNT_W-1:0]       w_diff;
    logic                   w_found;
    logic [NUM_IN_LOG2-1:0] w_winIdx;
    logic [CNT_W-1:0]       w_winCount;
    logic                   w_load;
    logic                   w_accept;

    // A back-to-back reload starts its tie-break just past the pick being
    // accepted; the pointer register only catches up on the same edge.
    assign w_base = (r_state == HOLD) ? r_pick + 1'b1 : r_rrPtr;

    // Scan in round-robin order; only a strictly earlier count displaces the
    // current best, so the first equal-minimum candidate in scan order wins.
    always_comb begin
        w_found    = 1'b0;
        w_winIdx   = '0;
        w_winCount = '0;
        w_idx      = '0;
        w_diff     = '0;
        for (int k = 0; k < N; k++) begin
            w_idx  = w_base + NUM_IN_LOG2'(k);
            w_diff = count[w_idx] - w_winCount;
            if (valid_i[w_idx] && (!w_found || w_diff[CNT_W-1])) begin
                w_found    = 1'b1;
                w_winIdx   = w_idx;
                w_winCount = count[w_idx];
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_found) begin
                    w_load      = 1'b1;
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (ready_i) begin
                    w_accept = 1'b1;
                    if (w_found) begin
                        w_load = 1'b1;
                    end else begin
                        w_nextState = EMPTY;
                    end
                end
            end
            default: w_nextState = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_pick      <= '0;
            r_pickCount <= '0;
            r_rrPtr     <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_load) begin
                r_pick      <= w_winIdx;
                r_pickCount <= w_winCount;
            end
            if (w_accept) begin
                r_rrPtr <= r_pick + 1'b1;
            end
        end
    end

    assign pick       = r_pick;
    assign pick_count = r_pickCount;
    assign valid_o    = (r_state == HOLD);

endmodule

// File: tb/tb_fair_pick.sv
// Randomized and directed bench for fair_pick against a rule-level model of
// oldest-count-first selection with round-robin tie-break.
module tb_fair_pick;

    localparam int LOG2 = 3;
    localparam int N    = 8;
    localparam int W    = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [W-1:0]    count   [N];
    logic            valid_i [N];
    logic            ready_i;
    logic [LOG2-1:0] pick;
    logic [W-1:0]    pick_count;
    logic            valid_o;

    int checks = 0;
    int errors = 0;

    bit          mValid;
    int          mPick;
    logic [31:0] mCount;
    int          mRr;

    fair_pick #(.NUM_IN_LOG2(LOG2), .CNT_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .count      (count),
        .valid_i    (valid_i),
        .ready_i    (ready_i),
        .pick       (pick),
        .pick_count (pick_count),
        .valid_o    (valid_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Winner = valid channel that no other valid channel is strictly older
    // than; among those, the one closest to base going upward with wrap.
    function automatic int refWinner(input int base);
        int best     = -1;
        int bestDist = N;
        for (int i = 0; i < N; i++) begin
            bit beaten = 0;
            if (!valid_i[i]) continue;
            for (int j = 0; j < N; j++) begin
                logic signed [31:0] d;
                d = count[j] - count[i];
                if (valid_i[j] && d < 0) beaten = 1;
            end
            if (!beaten && ((i - base + N) % N) < bestDist) begin
                bestDist = (i - base + N) % N;
                best     = i;
            end
        end
        return best;
    endfunction

    task automatic modelEdge();
        int w;
        if (!mValid) begin
            w = refWinner(mRr);
            if (w >= 0) begin
                mValid = 1;
                mPick  = w;
                mCount = count[w];
            end
        end else if (ready_i) begin
            mRr = (mPick + 1) % N;
            w   = refWinner(mRr);
            if (w >= 0) begin
                mPick  = w;
                mCount = count[w];
            end else begin
                mValid = 0;
            end
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".valid"}, 32'(valid_o), 32'(mValid));
        checkOutput({tag, ".pick"}, 32'(pick), 32'(mPick));
        checkOutput({tag, ".count"}, pick_count, mCount);
    endtask

    task automatic applyStimulus(input string tag);
        modelEdge();
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    task automatic clearInputs();
        for (int i = 0; i < N; i++) begin
            valid_i[i] = 1'b0;
            count[i]   = '0;
        end
    endtask

    task automatic setAllEqual(input logic [31:0] v);
        for (int i = 0; i < N; i++) begin
            valid_i[i] = 1'b1;
            count[i]   = v;
        end
    endtask

    task automatic doReset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        mValid = 0;
        mPick  = 0;
        mCount = 0;
        mRr    = 0;
        checkAll(tag);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        ready_i = 1'b0;
        clearInputs();
        mValid = 0;
        mPick  = 0;
        mCount = 0;
        mRr    = 0;
        #3;
        checkAll("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic pick of the smaller of two counts
        valid_i[1] = 1'b1; count[1] = 20;
        valid_i[2] = 1'b1; count[2] = 7;
        ready_i    = 1'b1;
        applyStimulus("basic");
        checkOutput("basic.pick2", 32'(pick), 32'd2);
        checkOutput("basic.cnt7", pick_count, 32'd7);
        clearInputs();
        applyStimulus("basicDrain");
        applyStimulus("idle");

        // Round-robin rotation over an all-equal tie from a fresh pointer
        doReset("rst2");
        setAllEqual(32'd5);
        ready_i = 1'b1;
        for (int c = 0; c < 9; c++) begin
            applyStimulus("rr");
            checkOutput("rr.seq", 32'(pick), 32'(c % N));
        end
        clearInputs();
        applyStimulus("rrDrain");

        // Wrap-aware ordering
        valid_i[3] = 1'b1; count[3] = 32'hFFFF_FFFE;
        valid_i[4] = 1'b1; count[4] = 32'h0000_0002;
        applyStimulus("wrap");
        checkOutput("wrap.pick3", 32'(pick), 32'd3);
        clearInputs();
        applyStimulus("wrapDrain");

        // Backpressure holds the pick while inputs move underneath it
        ready_i    = 1'b0;
        valid_i[5] = 1'b1; count[5] = 100;
        applyStimulus("bp");
        checkOutput("bp.pick5", 32'(pick), 32'd5);
        for (int c = 0; c < 4; c++) begin
            count[5]   = 32'(50 + c);
            valid_i[5] = c[0];
            valid_i[0] = 1'b1;
            count[0]   = 10;
            applyStimulus("bpHold");
        end
        ready_i = 1'b1;
        applyStimulus("bpRel");
        checkOutput("bp.pick0", 32'(pick), 32'd0);
        clearInputs();
        applyStimulus("bpDrain");

        // Drain then ready toggling in EMPTY must not move the pointer
        valid_i[6] = 1'b1; count[6] = 3;
        applyStimulus("drainLoad");
        clearInputs();
        applyStimulus("drainFall");
        checkOutput("drain.valid0", 32'(valid_o), 32'd0);
        for (int c = 0; c < 4; c++) begin
            ready_i = c[0];
            applyStimulus("emptyRdy");
        end
        ready_i = 1'b0;
        setAllEqual(32'd9);
        applyStimulus("drainTie");
        checkOutput("drain.pick7", 32'(pick), 32'd7);

        // Asynchronous reset mid-HOLD, then fresh selection with pointer 0
        doReset("asyncRst");
        applyStimulus("postRst");
        checkOutput("postRst.pick0", 32'(pick), 32'd0);

        // Randomized traffic with small count spreads to provoke ties and wrap
        for (int c = 0; c < 400; c++) begin
            logic [31:0] base;
            base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
            for (int i = 0; i < N; i++) begin
                valid_i[i] = ($urandom_range(0, 2) != 0);
                count[i]   = base + $urandom_range(0, 7);
            end
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < N; i++) valid_i[i] = 1'b0;
            end
            ready_i = ($urandom_range(0, 3) != 0);
            applyStimulus("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
